// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared definitions for the FIFO write-side controller: FSM encoding and
// counter widths, also used by the matching read-side controller.
package fifo_wr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WRITE  = 2'd2
  } wr_state_e;

  localparam int BURST_CNT_W  = 16;
  localparam int SETTLE_CNT_W = 8;

endpackage : fifo_wr_ctrl_pkg

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side FIFO port: status flags from the FIFO, enable/data towards it.
interface fifo_wr_ctrl_if #(
  parameter int DATA_W = 8
);

  logic              wr_rst_busy;
  logic              empty;
  logic              almost_full;
  logic              full;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;

  // The controller drives writes; the FIFO drives status.
  modport master (
    input  wr_rst_busy, empty, almost_full, full,
    output fifo_wr_en, fifo_wr_data
  );

  modport slave (
    output wr_rst_busy, empty, almost_full, full,
    input  fifo_wr_en, fifo_wr_data
  );

endinterface : fifo_wr_ctrl_if

// File: rtl/fifo_wr_ctrl_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic d0;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      d0 <= d;
      q  <= d0;
    end
  end

endmodule : sync_2ff

// File: rtl/fifo_wr_ctrl.sv
// FIFO write-side controller: once the FIFO drains empty, waits a settle
// period and then writes an incrementing pattern until almost_full/full.
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int SETTLE_CYC = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fifo_wr_ctrl_if.master         wr,
  output logic [BURST_CNT_W-1:0] burst_cnt,
  output logic                   overflow_err
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYC - 1);

  wr_state_e               state_q, state_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [BURST_CNT_W-1:0]  burst_q, burst_d;
  logic                    ovf_q, ovf_d;
  logic                    empty_d1;

  // empty comes from the read clock domain; only the synchronized copy is used.
  sync_2ff #(.RST_VAL(1'b0)) u_empty_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (wr.empty),
    .q     (empty_d1)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en_d = wr_en_q;
    data_d  = data_q;
    burst_d = burst_q;
    ovf_d   = ovf_q | (wr_en_q & wr.full);

    if (wr.wr_rst_busy) begin
      state_d = ST_IDLE;
      wr_en_d = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          wr_en_d = 1'b0;
          if (empty_d1) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end
        end
        ST_SETTLE: begin
          cnt_d = cnt_q + SETTLE_CNT_W'(1);
          // empty is only a start trigger; a drop here does not abort.
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_WRITE;
            wr_en_d = 1'b1;
            data_d  = '0;
          end
        end
        ST_WRITE: begin
          if (wr_en_q && !wr.full) data_d = data_q + DATA_W'(1);
          // The write presented on the exit cycle still lands if not full.
          if (wr.almost_full || wr.full) begin
            state_d = ST_IDLE;
            wr_en_d = 1'b0;
            burst_d = burst_q + BURST_CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          wr_en_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
      burst_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      burst_q <= burst_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr.fifo_wr_en   = wr_en_q;
  assign wr.fifo_wr_data = data_q;
  assign burst_cnt       = burst_q;
  assign overflow_err    = ovf_q;

endmodule : fifo_wr_ctrl

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: an 8-bit instance against a depth-16 FIFO
// model and a 4-bit instance for data wrap.
module tb_fifo_wr_ctrl;
  import fifo_wr_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_ctrl_if #(.DATA_W(8)) bus  ();
  fifo_wr_ctrl_if #(.DATA_W(4)) bus4 ();

  logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt4;
  logic                   ovf, ovf4;

  fifo_wr_ctrl #(.DATA_W(8), .SETTLE_CYC(10)) u_dut (
    .clk (clk), .rst_n (rst_n), .wr (bus.master),
    .burst_cnt (burst_cnt), .overflow_err (ovf)
  );

  fifo_wr_ctrl #(.DATA_W(4), .SETTLE_CYC(10)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .wr (bus4.master),
    .burst_cnt (burst_cnt4), .overflow_err (ovf4)
  );

  int checks = 0;
  int errors = 0;

  // Depth-16 FIFO model; almost_full rises as the 15th entry is presented.
  int         fill = 0;
  logic       drain = 1'b0;
  logic       ovr = 1'b0;
  logic       af_drv = 1'b0;
  logic       full_drv = 1'b0;
  logic [7:0] wq[$];

  assign bus.full        = ovr ? full_drv : (fill >= 16);
  assign bus.almost_full = ovr ? af_drv
                               : ((fill + int'(bus.fifo_wr_en && fill < 16)) >= 15);

  always @(posedge clk) begin
    if (drain) fill <= 0;
    else if (bus.fifo_wr_en && !bus.full) begin
      fill <= fill + 1;
      wq.push_back(bus.fifo_wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_fifo();
    drain = 1'b1;
    tick();
    drain = 1'b0;
  endtask

  task automatic wait_en(input logic val, input int budget, input string name);
    int n = 0;
    while (bus.fifo_wr_en !== val && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (bus.fifo_wr_en !== val) begin
      errors++;
      $display("FAIL %s: fifo_wr_en=%b required %b within %0d cycles", name, bus.fifo_wr_en, val, budget);
    end
  endtask

  task automatic check_burst_data(input int base, input int len, input string name);
    checks++;
    if (wq.size() - base !== len) begin
      errors++;
      $display("FAIL %s count: writes=%0d required %0d", name, wq.size() - base, len);
    end else begin
      for (int i = 0; i < len; i++) begin
        checks++;
        if (wq[base+i] !== 8'(i)) begin
          errors++;
          $display("FAIL %s word %0d: data=%0d required %0d", name, i, wq[base+i], i);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_rst_busy  = 1'b0;
    bus.empty        = 1'b1;
    bus4.wr_rst_busy = 1'b0;
    bus4.empty       = 1'b0;
    bus4.almost_full = 1'b0;
    bus4.full        = 1'b0;
    #12;
    checks++;
    if ({bus.fifo_wr_en, bus.fifo_wr_data, burst_cnt, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b data=%0d burst=%0d ovf=%b required all 0",
               bus.fifo_wr_en, bus.fifo_wr_data, burst_cnt, ovf);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      checks++;
      if (bus.fifo_wr_en !== (i == 13)) begin
        errors++;
        $display("FAIL start_latency edge %0d: fifo_wr_en=%b required %b", i, bus.fifo_wr_en, i == 13);
      end
    end
    checks++;
    if (bus.fifo_wr_data !== 8'd0) begin
      errors++;
      $display("FAIL start_data: data=%0d required 0", bus.fifo_wr_data);
    end
    bus.empty = 1'b0;
  endtask

  task automatic test_burst();
    int base = wq.size();
    int n = 0;
    while (!bus.almost_full && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (bus.almost_full !== 1'b1 || bus.fifo_wr_data !== 8'd14) begin
      errors++;
      $display("FAIL burst_af: almost_full=%b data=%0d required 1 and 14", bus.almost_full, bus.fifo_wr_data);
    end
    tick();
    checks++;
    if (bus.fifo_wr_en !== 1'b0 || burst_cnt !== 16'd1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL burst_end: en=%b burst=%0d ovf=%b required 0 1 0", bus.fifo_wr_en, burst_cnt, ovf);
    end
    check_burst_data(base, 15, "burst_data");
  endtask

  task automatic test_rst_busy();
    int base;
    int n = 0;
    drain_fifo();
    bus.empty = 1'b1;
    wait_en(1'b1, 30, "busy_start");
    bus.empty = 1'b0;
    while (bus.fifo_wr_data !== 8'd5 && n < 20) begin
      tick();
      n++;
    end
    bus.wr_rst_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.fifo_wr_en !== 1'b0 || bus.fifo_wr_data !== 8'd5 || burst_cnt !== 16'd1) begin
        errors++;
        $display("FAIL busy_hold %0d: en=%b data=%0d burst=%0d required 0 5 1",
                 i, bus.fifo_wr_en, bus.fifo_wr_data, burst_cnt);
      end
    end
    bus.wr_rst_busy = 1'b0;
    tick();
    checks++;
    if (bus.fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle: en=%b required 0", bus.fifo_wr_en);
    end
    drain_fifo();
    bus.empty = 1'b1;
    wait_en(1'b1, 30, "busy_restart");
    bus.empty = 1'b0;
    base = wq.size();
    checks++;
    if (bus.fifo_wr_data !== 8'd0) begin
      errors++;
      $display("FAIL busy_restart_data: data=%0d required 0", bus.fifo_wr_data);
    end
    wait_en(1'b0, 40, "busy_burst_end");
    checks++;
    if (burst_cnt !== 16'd2) begin
      errors++;
      $display("FAIL busy_burst_cnt: burst=%0d required 2", burst_cnt);
    end
    check_burst_data(base, 15, "busy_burst_data");
  endtask

  task automatic test_overflow();
    drain_fifo();
    ovr = 1'b1;
    bus.empty = 1'b1;
    wait_en(1'b1, 30, "ovf_start");
    bus.empty = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.fifo_wr_data !== 8'd2 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pre: data=%0d ovf=%b required 2 0", bus.fifo_wr_data, ovf);
    end
    full_drv = 1'b1;
    tick();
    checks++;
    if (ovf !== 1'b1 || bus.fifo_wr_en !== 1'b0 || bus.fifo_wr_data !== 8'd2 || burst_cnt !== 16'd3) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b en=%b data=%0d burst=%0d required 1 0 2 3",
               ovf, bus.fifo_wr_en, bus.fifo_wr_data, burst_cnt);
    end
    full_drv = 1'b0;
    tick();
    tick();
    checks++;
    if (ovf !== 1'b1 || bus.fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL ovf_idle: ovf=%b en=%b required 1 0", ovf, bus.fifo_wr_en);
    end
    ovr = 1'b0;
    drain_fifo();
    bus.empty = 1'b1;
    wait_en(1'b1, 30, "ovf_next_start");
    bus.empty = 1'b0;
    wait_en(1'b0, 40, "ovf_next_end");
    checks++;
    if (ovf !== 1'b1 || burst_cnt !== 16'd4) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b burst=%0d required 1 4", ovf, burst_cnt);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    bus4.empty = 1'b1;
    while (bus4.fifo_wr_en !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    bus4.empty = 1'b0;
    checks++;
    if (bus4.fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL wrap_start: en=%b required 1", bus4.fifo_wr_en);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (bus4.fifo_wr_data !== 4'(i)) begin
        errors++;
        $display("FAIL wrap_data %0d: data=%0d required %0d", i, bus4.fifo_wr_data, i % 16);
      end
      tick();
    end
    bus4.almost_full = 1'b1;
    tick();
    bus4.almost_full = 1'b0;
    checks++;
    if (bus4.fifo_wr_en !== 1'b0 || burst_cnt4 !== 16'd1 || ovf4 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: en=%b burst=%0d ovf=%b required 0 1 0", bus4.fifo_wr_en, burst_cnt4, ovf4);
    end
  endtask

  task automatic test_async_reset();
    drain_fifo();
    bus.empty = 1'b1;
    wait_en(1'b1, 30, "arst_start");
    bus.empty = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.fifo_wr_en, bus.fifo_wr_data, burst_cnt, ovf} !== '0 || {burst_cnt4, ovf4} !== '0) begin
      errors++;
      $display("FAIL async_reset: en=%b data=%0d burst=%0d ovf=%b burst4=%0d ovf4=%b required all 0",
               bus.fifo_wr_en, bus.fifo_wr_data, burst_cnt, ovf, burst_cnt4, ovf4);
    end
    #10;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_burst();
    test_rst_busy();
    test_overflow();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_wr_ctrl
